// File: rtl/stall_buf_pkg.sv
// Shared sizing defaults and helpers for the global-stall pipeline buffers.
package stall_buf_pkg;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_DEPTH     = 8;
   localparam int unsigned DEF_AF_THRESH = 6;

   // Index width that never collapses to zero bits.
   function automatic int unsigned clog2_safe(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stall_buf_mem.sv
// Storage for the stall buffer: synchronous write, combinational read.
module stall_buf_mem
   import stall_buf_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = clog2_safe(DEF_DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stall_skid_fifo.sv
// Stall buffer between pipeline stages: queues words under global stall,
// drains oldest-first when released, registered bypass when empty.
module stall_skid_fifo
   import stall_buf_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned AF_THRESH = DEF_AF_THRESH,
   localparam int unsigned CW       = $clog2(DEPTH + 1),
   localparam int unsigned PW       = clog2_safe(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             full,
   output logic             almost_full,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
      $error("stall_skid_fifo: need DEPTH >= 2 and 1 <= AF_THRESH <= DEPTH");
   end

   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_overflow;

   logic             w_full;
   logic             w_nempty;
   logic             w_we;
   logic [WIDTH-1:0] w_rdata;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_nempty = (r_count != '0);

   always_comb begin
      w_we = 1'b0;
      if (!flush) begin
         if (stall) begin
            w_we = in_valid && !w_full;
         end else if (w_nempty) begin
            w_we = in_valid;
         end
      end
   end

   stall_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_tail),
      .i_wdata (in_data),
      .i_raddr (r_head),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_overflow  <= 1'b0;
      end else if (flush) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_overflow  <= 1'b0;
      end else if (stall) begin
         r_out_valid <= 1'b0;
         if (in_valid) begin
            if (!w_full) begin
               r_tail  <= f_nxt(r_tail);
               r_count <= r_count + 1'b1;
            end else begin
               r_overflow <= 1'b1;
            end
         end
      end else if (w_nempty) begin
         // Dequeue head; a concurrent arrival refills the freed slot.
         r_out_data  <= w_rdata;
         r_out_valid <= 1'b1;
         r_head      <= f_nxt(r_head);
         if (in_valid) begin
            r_tail <= f_nxt(r_tail);
         end else begin
            r_count <= r_count - 1'b1;
         end
      end else begin
         r_out_data  <= in_data;
         r_out_valid <= in_valid;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign full        = w_full;
   assign almost_full = (r_count >= CW'(AF_THRESH));
   assign count       = r_count;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_stall_skid_fifo.sv
// Directed bench for stall_skid_fifo at WIDTH=32, DEPTH=8, AF_THRESH=6.
module tb_stall_skid_fifo;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        full;
   logic        almost_full;
   logic [3:0]  count;
   logic        overflow;

   int total;
   int bad;

   stall_skid_fifo #(
      .WIDTH     (32),
      .DEPTH     (8),
      .AF_THRESH (6)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] d);
      chk({tag, ".v"}, 64'(out_valid), 64'(v));
      if (v) chk({tag, ".d"}, 64'(out_data), 64'(d));
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      stall    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #12;
      chk("rst.ov", 64'(out_valid), 0);
      chk("rst.od", 64'(out_data), 0);
      chk("rst.cnt", 64'(count), 0);
      chk("rst.full", 64'(full), 0);
      chk("rst.af", 64'(almost_full), 0);
      chk("rst.ovf", 64'(overflow), 0);
      step();
      reset = 1'b0;

      // bypass
      in_valid = 1'b1;
      in_data = 32'hA1; step(); chk_out("byp1", 1, 32'hA1);
      chk("byp1.cnt", 64'(count), 0);
      in_data = 32'hA2; step(); chk_out("byp2", 1, 32'hA2);
      in_data = 32'hA3; step(); chk_out("byp3", 1, 32'hA3);
      chk("byp3.cnt", 64'(count), 0);
      in_valid = 1'b0;
      step(); chk_out("byp.idle", 0, 0);

      // fill under stall
      stall = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h10 + 32'(i);
         step();
         chk("fill.cnt", 64'(count), 64'(i + 1));
         chk("fill.af", 64'(almost_full), 64'(i + 1 >= 6));
         chk("fill.full", 64'(full), 64'(i + 1 == 8));
         chk("fill.ov", 64'(out_valid), 0);
         chk("fill.ovf", 64'(overflow), 0);
      end
      in_data = 32'h18; step();
      chk("ovf.flag", 64'(overflow), 1);
      chk("ovf.cnt", 64'(count), 8);
      chk("ovf.full", 64'(full), 1);

      // drain from full with concurrent input
      stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h20 + 32'(i);
         step();
         chk_out("drc", 1, 32'h10 + 32'(i));
         chk("drc.cnt", 64'(count), 8);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk_out("drn", 1, 32'h20 + 32'(i));
         chk("drn.cnt", 64'(count), 64'(7 - i));
      end
      step(); chk_out("drn.idle", 0, 0);
      chk("drn.ovf", 64'(overflow), 1);

      // wrap-around: push 5, drain 5, push 7
      stall = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h30 + 32'(i); step();
      end
      chk("w5.cnt", 64'(count), 5);
      stall = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); chk_out("w5", 1, 32'h30 + 32'(i));
      end
      chk("w5.empty", 64'(count), 0);
      stall = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = 32'h40 + 32'(i); step();
      end
      chk("w7.cnt", 64'(count), 7);
      chk("w7.af", 64'(almost_full), 1);
      stall = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk_out("w7", 1, 32'h40 + 32'(i));
         chk("w7.dcnt", 64'(count), 64'(6 - i));
      end
      step(); chk_out("w7.idle", 0, 0);

      // stall mid-drain
      stall = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 32'h50 + 32'(i); step();
      end
      stall = 1'b0; in_valid = 1'b0;
      step(); chk_out("md1", 1, 32'h50); chk("md1.cnt", 64'(count), 3);
      step(); chk_out("md2", 1, 32'h51); chk("md2.cnt", 64'(count), 2);
      stall = 1'b1;
      step();
      chk("mds.ov", 64'(out_valid), 0);
      chk("mds.od", 64'(out_data), 32'h51);
      chk("mds.cnt", 64'(count), 2);
      stall = 1'b0;
      step(); chk_out("md3", 1, 32'h52);
      step(); chk_out("md4", 1, 32'h53); chk("md4.cnt", 64'(count), 0);

      // flush with count=5 and overflow set
      stall = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h60 + 32'(i); step();
      end
      chk("fl.pre.cnt", 64'(count), 5);
      chk("fl.pre.ovf", 64'(overflow), 1);
      flush = 1'b1; in_data = 32'h6F; step();
      chk("fl.cnt", 64'(count), 0);
      chk("fl.ovf", 64'(overflow), 0);
      chk("fl.ov", 64'(out_valid), 0);
      chk("fl.od", 64'(out_data), 0);
      flush = 1'b0; stall = 1'b0;
      in_data = 32'h77; step(); chk_out("fl.byp", 1, 32'h77);

      // async reset between edges, mid-drain
      stall = 1'b1;
      in_data = 32'h81; step();
      in_data = 32'h82; step();
      stall = 1'b0; in_valid = 1'b0;
      step(); chk_out("ar.pre", 1, 32'h81);
      chk("ar.pre.cnt", 64'(count), 1);
      #2 reset = 1'b1;
      #1;
      chk("ar.ov", 64'(out_valid), 0);
      chk("ar.od", 64'(out_data), 0);
      chk("ar.cnt", 64'(count), 0);
      step();
      reset = 1'b0;
      in_valid = 1'b1; in_data = 32'h99; step();
      chk_out("ar.byp", 1, 32'h99);
      chk("ar.byp.cnt", 64'(count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
